// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - write/read port bundle for the register file
//
// Purpose: groups the writeback write port and the two read ports.
// Ports (signals):
//   Reg_Write        write enable, sampled at posedge clk
//   Write_Register   destination register index
//   Write_Data       data to write
//   Read_Register_1  read port 1 index (rs)
//   Read_Register_2  read port 2 index (rt)
//   Read_Data_1      read port 1 data
//   Read_Data_2      read port 2 data
// Modports: master drives writes/read indices, slave is the register file.
interface register_file_if #(
  parameter int BIT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  Reg_Write;
  logic [ADDR_WIDTH-1:0] Write_Register;
  logic [BIT_WIDTH-1:0]  Write_Data;
  logic [ADDR_WIDTH-1:0] Read_Register_1;
  logic [ADDR_WIDTH-1:0] Read_Register_2;
  logic [BIT_WIDTH-1:0]  Read_Data_1;
  logic [BIT_WIDTH-1:0]  Read_Data_2;

  modport master (
    output Reg_Write, Write_Register, Write_Data,
    output Read_Register_1, Read_Register_2,
    input  Read_Data_1, Read_Data_2
  );

  modport slave (
    input  Reg_Write, Write_Register, Write_Data,
    input  Read_Register_1, Read_Register_2,
    output Read_Data_1, Read_Data_2
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - MIPS general-purpose register file, 1 write / 2 read ports
//
// Purpose: 2**ADDR_WIDTH entries of BIT_WIDTH bits, register 0 hardwired to
// zero, synchronous write, combinational reads with optional write bypass.
// Ports:
//   clk  system clock, writes on the rising edge
//   rst  asynchronous active-low reset, clears every entry
//   bus  register_file_if.slave: write port and the two read ports
module register_file #(
  parameter int BIT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS_EN  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  register_file_if.slave        bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [BIT_WIDTH-1:0] regs [DEPTH];

  // Entry 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.Reg_Write && (bus.Write_Register != '0)) begin
      regs[bus.Write_Register] <= bus.Write_Data;
    end
  end

  // Reads are gated by rst so a bypassed write cannot leak out during reset,
  // and index 0 is forced to zero ahead of the bypass path.
  always_comb begin
    bus.Read_Data_1 = '0;
    if (rst && (bus.Read_Register_1 != '0)) begin
      if ((BYPASS_EN != 0) && bus.Reg_Write &&
          (bus.Write_Register == bus.Read_Register_1)) begin
        bus.Read_Data_1 = bus.Write_Data;
      end else begin
        bus.Read_Data_1 = regs[bus.Read_Register_1];
      end
    end
  end

  always_comb begin
    bus.Read_Data_2 = '0;
    if (rst && (bus.Read_Register_2 != '0)) begin
      if ((BYPASS_EN != 0) && bus.Reg_Write &&
          (bus.Write_Register == bus.Read_Register_2)) begin
        bus.Read_Data_2 = bus.Write_Data;
      end else begin
        bus.Read_Data_2 = regs[bus.Read_Register_2];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file, both bypass modes
module tb_register_file;

  logic clk;
  logic rst;

  register_file_if #(.BIT_WIDTH(32), .ADDR_WIDTH(5)) bus0 ();
  register_file_if #(.BIT_WIDTH(32), .ADDR_WIDTH(5)) bus1 ();

  register_file #(.BIT_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(0)) dut_nobyp (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  register_file #(.BIT_WIDTH(32), .ADDR_WIDTH(5), .BYPASS_EN(1)) dut_byp (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];
  logic        we;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
    bus0.Reg_Write = w; bus0.Write_Register = a; bus0.Write_Data = d;
    bus0.Read_Register_1 = r1; bus0.Read_Register_2 = r2;
    bus1.Reg_Write = w; bus1.Write_Register = a; bus1.Write_Data = d;
    bus1.Read_Register_1 = r1; bus1.Read_Register_2 = r2;
  endtask

  // Reference: architectural register state, updated at each edge.
  task automatic step();
    @(posedge clk);
    if (rst && we && wa != 5'd0) model[wa] = wd;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  function automatic logic [31:0] expect_rd(input bit byp, input logic [4:0] a);
    if (!rst || a == 5'd0) return 32'h0;
    if (byp && we && wa == a) return wd;
    return model[a];
  endfunction

  task automatic check_all_reads(input string tag);
    check({tag, "_nb_rd1"}, bus0.Read_Data_1, expect_rd(1'b0, ra1));
    check({tag, "_nb_rd2"}, bus0.Read_Data_2, expect_rd(1'b0, ra2));
    check({tag, "_by_rd1"}, bus1.Read_Data_1, expect_rd(1'b1, ra1));
    check({tag, "_by_rd2"}, bus1.Read_Data_2, expect_rd(1'b1, ra2));
  endtask

  initial begin
    rst = 1'b0;
    clear_model();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #12;
    // Reset state: every address reads zero on both ports of both instances.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      #1;
      check("reset_rd1", bus0.Read_Data_1, 32'h0);
      check("reset_rd2", bus1.Read_Data_2, 32'h0);
    end
    // Writes while reset is low are ignored.
    drive(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9);
    step();
    check("wr_in_reset_nb", bus0.Read_Data_1, 32'h0);
    check("wr_in_reset_by", bus1.Read_Data_1, 32'h0);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    #1;
    check("wr_in_reset_rel", bus0.Read_Data_1, 32'h0);

    // Async reset mid-cycle clears r5 before any edge.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    #1;
    check("r5_written", bus0.Read_Data_1, 32'hDEADBEEF);
    rst = 1'b0;
    #1;
    check("async_rst_nb", bus0.Read_Data_1, 32'h0);
    check("async_rst_by", bus1.Read_Data_1, 32'h0);
    clear_model();
    step();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
      #1;
      check("post_rst_all", bus0.Read_Data_1, 32'h0);
    end

    // Basic write/read on r1 and r31.
    drive(1'b1, 5'd1, 32'h12345678, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd31, 32'hFFFFFFFF, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    #1;
    check("basic_r1", bus0.Read_Data_1, 32'h12345678);
    check("basic_r31", bus0.Read_Data_2, 32'hFFFFFFFF);
    check("basic_r1_by", bus1.Read_Data_1, 32'h12345678);

    // r0 protection in both modes.
    drive(1'b1, 5'd0, 32'hA5A5A5A5, 5'd0, 5'd0);
    #1;
    check("r0_pre_nb1", bus0.Read_Data_1, 32'h0);
    check("r0_pre_nb2", bus0.Read_Data_2, 32'h0);
    check("r0_pre_by1", bus1.Read_Data_1, 32'h0);
    check("r0_pre_by2", bus1.Read_Data_2, 32'h0);
    step();
    check("r0_post_nb", bus0.Read_Data_1, 32'h0);
    check("r0_post_by", bus1.Read_Data_2, 32'h0);

    // Write disable.
    drive(1'b1, 5'd7, 32'h00000011, 5'd7, 5'd7);
    step();
    drive(1'b0, 5'd7, 32'h00000022, 5'd7, 5'd7);
    step();
    check("wr_disable_nb", bus0.Read_Data_1, 32'h00000011);
    check("wr_disable_by", bus1.Read_Data_2, 32'h00000011);

    // Same-cycle hazard on r3.
    drive(1'b1, 5'd3, 32'h1, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd3, 32'h2, 5'd3, 5'd3);
    #1;
    check("hazard_pre_nb1", bus0.Read_Data_1, 32'h1);
    check("hazard_pre_nb2", bus0.Read_Data_2, 32'h1);
    check("hazard_pre_by1", bus1.Read_Data_1, 32'h2);
    check("hazard_pre_by2", bus1.Read_Data_2, 32'h2);
    step();
    drive(1'b0, 5'd3, 32'h2, 5'd3, 5'd3);
    #1;
    check("hazard_post_nb1", bus0.Read_Data_1, 32'h2);
    check("hazard_post_nb2", bus0.Read_Data_2, 32'h2);

    // Random regression against the array model.
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] a, r1, r2;
      a  = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 3) != 0), a, $urandom, r1, r2);
      #2;
      check_all_reads("rand");
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        #1;
        clear_model();
        check_all_reads("rand_rst");
        rst = 1'b1;
        #1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
